fu_issue_arbiter: RTL

//  Shares one functional_unit between N_REQ requesters. Round-robin arbitration picks one op per cycle and

---
 rtl/fu_issue_arbiter.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/fu_issue_arbiter.sv
// Purpose : round-robin issue of one op per cycle from N_REQ requesters onto a shared,
//           fully pipelined functional unit, with writeback-collision blocking and flush/drain.
// Latency : grant (cycle k) -> FU_* registered at k+1 -> RSP_* at k+2+LAT (LAT by op class).
// Backpr. : REQ_READY is the combinational grant; a requester waits while its slot is
//           occupied, FLUSH is high or the FSM is draining. Responses cannot be stalled.
//
// Ports:
//   CLOCK, RESET          clock, synchronous active-high reset
//   REQ_VALID/REQ_READY   per-requester valid and one-hot grant
//   REQ_INST/A/B/C/SELECT packed per-requester op fields (requester i at slice i)
//   FU_INST/A/B/C/SELECT  registered operands to the functional unit
//   FU_Z, FU_COMPARE      functional unit results
//   RSP_VALID/ID/Z/COMPARE registered result, tagged with the issuing requester
//   FLUSH, FLUSH_DONE     stop granting and drain; FLUSH_DONE high once drained
module fu_issue_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int LAT_SHORT = 1,
    parameter int LAT_MADD  = 3
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [N_REQ-1:0]      REQ_VALID,
    output logic [N_REQ-1:0]      REQ_READY,
    input  logic [6*N_REQ-1:0]    REQ_INST,
    input  logic [32*N_REQ-1:0]   REQ_A,
    input  logic [32*N_REQ-1:0]   REQ_B,
    input  logic [32*N_REQ-1:0]   REQ_C,
    input  logic [N_REQ-1:0]      REQ_SELECT,
    output logic [5:0]            FU_INST,
    output logic [31:0]           FU_A,
    output logic [31:0]           FU_B,
    output logic [31:0]           FU_C,
    output logic                  FU_SELECT,
    input  logic [31:0]           FU_Z,
    input  logic                  FU_COMPARE,
    output logic                  RSP_VALID,
    output logic [ID_W-1:0]       RSP_ID,
    output logic [31:0]           RSP_Z,
    output logic                  RSP_COMPARE,
    input  logic                  FLUSH,
    output logic                  FLUSH_DONE
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic [5:0]  inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        sel;
    } req_t;

    // One tracker slot: whose result shows up on FU_Z in a given future cycle.
    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } slot_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    // trk_q[j] describes the result that is on FU_Z j cycles from now.
    slot_t [LAT_MADD:0]  trk_q, trk_d;

    logic [5:0]          fu_inst_q, fu_inst_d;
    logic [31:0]         fu_a_q, fu_a_d;
    logic [31:0]         fu_b_q, fu_b_d;
    logic [31:0]         fu_c_q, fu_c_d;
    logic                fu_sel_q, fu_sel_d;

    logic                rsp_vld_q, rsp_vld_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [31:0]         rsp_z_q, rsp_z_d;
    logic                rsp_cmp_q, rsp_cmp_d;

    // ------------------------------------------------------------------
    // Unpack per-requester fields
    // ------------------------------------------------------------------
    req_t req_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_arr[g] = '{inst: REQ_INST[6*g +: 6],
                              a:    REQ_A[32*g +: 32],
                              b:    REQ_B[32*g +: 32],
                              c:    REQ_C[32*g +: 32],
                              sel:  REQ_SELECT[g]};
    end

    // ------------------------------------------------------------------
    // Candidate search: first valid requester at or after ptr, with wrap.
    // Walking offsets from the far end means the nearest offset is written last.
    // ------------------------------------------------------------------
    logic             cand_vld;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        logic [IDX_W:0] sum;
        sum      = '0;
        cand_vld = 1'b0;
        cand_idx = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            if (REQ_VALID[sum[IDX_W-1:0]]) begin
                cand_vld = 1'b1;
                cand_idx = sum[IDX_W-1:0];
            end
        end
    end

    req_t cand;
    logic cand_madd;
    logic cand_blocked;
    logic grant;

    assign cand      = req_arr[cand_idx];
    assign cand_madd = (cand.inst[5:3] == 3'b111);

    // A short op issued now writes back LAT_SHORT+1 cycles from now, which is
    // trk_q[LAT_SHORT+1]. A MADD would need trk_q[LAT_MADD+1], which nothing
    // can occupy because MADD is the longest class, so MADD never blocks.
    // A blocked candidate stalls the whole search rather than letting a
    // lower-priority requester slip past it.
    assign cand_blocked = !cand_madd && trk_q[LAT_SHORT+1].vld;

    // RESET gating keeps READY low during reset even though state is only
    // cleared at the clock edge.
    assign grant = !RESET && (state_q == ST_RUN) && !FLUSH && cand_vld && !cand_blocked;

    assign REQ_READY = grant ? (N_REQ'(1) << cand_idx) : '0;

    // ------------------------------------------------------------------
    // Round-robin pointer
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            if (cand_idx == IDX_W'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = cand_idx + IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracker: shift toward slot 0, then drop the new op in at
    // the slot that will be current when its result appears.
    // ------------------------------------------------------------------
    logic trk_empty;

    always_comb begin
        trk_d = '0;
        for (int j = 0; j < LAT_MADD; j++) begin
            trk_d[j] = trk_q[j+1];
        end
        if (grant) begin
            if (cand_madd) begin
                trk_d[LAT_MADD] = '{vld: 1'b1, id: ID_W'(cand_idx)};
            end else begin
                trk_d[LAT_SHORT] = '{vld: 1'b1, id: ID_W'(cand_idx)};
            end
        end
    end

    always_comb begin
        trk_empty = 1'b1;
        for (int j = 0; j <= LAT_MADD; j++) begin
            if (trk_q[j].vld) begin
                trk_empty = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Flush FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (FLUSH)     state_d = ST_DRAIN;
            ST_DRAIN:   if (trk_empty) state_d = ST_DRAINED;
            ST_DRAINED: if (!FLUSH)    state_d = ST_RUN;
            default:                   state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // FU issue registers. Idle cycles send opcode 0; its result is never
    // tracked, so operands can simply hold.
    // ------------------------------------------------------------------
    always_comb begin
        fu_inst_d = 6'b000000;
        fu_a_d    = fu_a_q;
        fu_b_d    = fu_b_q;
        fu_c_d    = fu_c_q;
        fu_sel_d  = fu_sel_q;
        if (grant) begin
            fu_inst_d = cand.inst;
            fu_a_d    = cand.a;
            fu_b_d    = cand.b;
            fu_c_d    = cand.c;
            fu_sel_d  = cand.sel;
        end
    end

    // ------------------------------------------------------------------
    // Response: slot 0 says whether FU_Z is a real result this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        rsp_vld_d = trk_q[0].vld;
        rsp_id_d  = trk_q[0].id;
        rsp_z_d   = FU_Z;
        rsp_cmp_d = FU_COMPARE;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= ST_RUN;
            ptr_q     <= '0;
            trk_q     <= '0;
            fu_inst_q <= 6'b000000;
            fu_a_q    <= '0;
            fu_b_q    <= '0;
            fu_c_q    <= '0;
            fu_sel_q  <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
            rsp_z_q   <= '0;
            rsp_cmp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            trk_q     <= trk_d;
            fu_inst_q <= fu_inst_d;
            fu_a_q    <= fu_a_d;
            fu_b_q    <= fu_b_d;
            fu_c_q    <= fu_c_d;
            fu_sel_q  <= fu_sel_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
            rsp_z_q   <= rsp_z_d;
            rsp_cmp_q <= rsp_cmp_d;
        end
    end

    assign FU_INST     = fu_inst_q;
    assign FU_A        = fu_a_q;
    assign FU_B        = fu_b_q;
    assign FU_C        = fu_c_q;
    assign FU_SELECT   = fu_sel_q;
    assign RSP_VALID   = rsp_vld_q;
    assign RSP_ID      = rsp_id_q;
    assign RSP_Z       = rsp_z_q;
    assign RSP_COMPARE = rsp_cmp_q;
    assign FLUSH_DONE  = (state_q == ST_DRAINED);

endmodule
